// File: rtl/id_queue_stage_pkg.sv
// Shared decode definitions: opcode constants, operation enums, immediate formats and the
// packed micro-op layout carried on out_uop_o.
package id_queue_stage_pkg;

    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcOp32    = 7'b0111011;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    // Micro-op field offsets; bits above UOP_LAYOUT_W are zero.
    localparam int unsigned UOP_ALU_LSB  = 0;
    localparam int unsigned UOP_CLS_LSB  = 4;
    localparam int unsigned UOP_FN_LSB   = 7;
    localparam int unsigned UOP_WORD_BIT = 10;
    localparam int unsigned UOP_IMM_BIT  = 11;
    localparam int unsigned UOP_PC_BIT   = 12;
    localparam int unsigned UOP_CSR_LSB  = 13;
    localparam int unsigned UOP_LAYOUT_W = 15;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB
    } alu_op_e;

    typedef enum logic [2:0] {
        CmpEq = 3'd0, CmpNe = 3'd1, CmpLt = 3'd4, CmpGe = 3'd5, CmpLtu = 3'd6, CmpGeu = 3'd7
    } cmp_op_e;

    typedef enum logic [1:0] {ShiftSll, ShiftSrl, ShiftSra} shift_op_e;

    typedef enum logic [2:0] {LdB, LdH, LdW, LdD, LdBu, LdHu, LdWu} load_op_e;

    typedef enum logic [2:0] {StB, StH, StW, StD} store_op_e;

    typedef enum logic [1:0] {CsrNone, CsrWrite, CsrSet, CsrClear} csr_op_e;

    typedef enum logic [2:0] {
        ClsAlu, ClsLoad, ClsStore, ClsBranch, ClsJump, ClsCsr, ClsSys, ClsTrap
    } uop_class_e;

    typedef enum logic [2:0] {
        GenNone, GenI, GenS, GenB, GenU, GenJ, GenShamt, GenZimm
    } gen_type_e;

    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3);
        case (funct3)
            3'd0:    return AluAdd;
            3'd1:    return AluSll;
            3'd2:    return AluSlt;
            3'd3:    return AluSltu;
            3'd4:    return AluXor;
            3'd5:    return AluSrl;
            3'd6:    return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    function automatic logic [UOP_LAYOUT_W-1:0] pack_uop(
        input alu_op_e    alu,
        input uop_class_e cls,
        input logic [2:0] fn,
        input logic       word,
        input logic       use_imm,
        input logic       use_pc,
        input csr_op_e    csr
    );
        return {csr, use_pc, use_imm, word, fn, cls, alu};
    endfunction

endpackage

// File: rtl/id_queue_stage_decode_core.sv
// Pure combinational RV64I decoder: instruction -> register indices/enables, immediate,
// packed micro-op and illegal flag.
module id_queue_stage_decode_core
    import id_queue_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned UOP_W = 32
) (
    input  logic [ILEN-1:0]  inst,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             rs1_en,
    output logic             rs2_en,
    output logic             rd_en,
    output logic [XLEN-1:0]  imm,
    output logic [UOP_W-1:0] uop,
    output logic             illegal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    logic       ill, r1e, r2e, rde, word, use_imm, use_pc;
    alu_op_e    alu;
    uop_class_e cls;
    logic [2:0] fn;
    csr_op_e    csr;
    gen_type_e  gen;

    always_comb begin
        ill     = 1'b0;
        r1e     = 1'b0;
        r2e     = 1'b0;
        rde     = 1'b0;
        word    = 1'b0;
        use_imm = 1'b0;
        use_pc  = 1'b0;
        alu     = AluAdd;
        cls     = ClsAlu;
        fn      = 3'd0;
        csr     = CsrNone;
        gen     = GenNone;
        case (opc)
            OpcLui: begin
                rde = 1'b1; gen = GenU; alu = AluPassB; use_imm = 1'b1;
            end
            OpcAuipc: begin
                rde = 1'b1; gen = GenU; use_imm = 1'b1; use_pc = 1'b1;
            end
            OpcJal: begin
                rde = 1'b1; gen = GenJ; cls = ClsJump; use_pc = 1'b1;
            end
            OpcJalr: begin
                rde = 1'b1; r1e = 1'b1; gen = GenI; cls = ClsJump;
                ill = (f3 != 3'd0);
            end
            OpcBranch: begin
                r1e = 1'b1; r2e = 1'b1; gen = GenB; cls = ClsBranch; fn = f3;
                ill = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OpcLoad: begin
                rde = 1'b1; r1e = 1'b1; gen = GenI; cls = ClsLoad; fn = f3; use_imm = 1'b1;
                ill = (f3 == 3'd7);
            end
            OpcStore: begin
                r1e = 1'b1; r2e = 1'b1; gen = GenS; cls = ClsStore; fn = f3; use_imm = 1'b1;
                ill = f3[2];
            end
            OpcOpImm, OpcOpImm32: begin
                rde = 1'b1; r1e = 1'b1; use_imm = 1'b1; gen = GenI;
                word = (opc == OpcOpImm32);
                alu = alu_from_funct3(f3);
                if (f3 == 3'd1) begin
                    gen = GenShamt;
                    ill = word ? (f7 != 7'd0) : (inst[31:26] != 6'd0);
                end else if (f3 == 3'd5) begin
                    gen = GenShamt;
                    alu = inst[30] ? AluSra : AluSrl;
                    ill = word ? ({f7[6], f7[4:0]} != 6'd0) : ({inst[31], inst[29:26]} != 5'd0);
                end else if (word && f3 != 3'd0) begin
                    ill = 1'b1;
                end
            end
            OpcOp, OpcOp32: begin
                rde = 1'b1; r1e = 1'b1; r2e = 1'b1;
                word = (opc == OpcOp32);
                alu = alu_from_funct3(f3);
                if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    alu = (f3 == 3'd0) ? AluSub : AluSra;
                end else if (f7 != 7'd0) begin
                    ill = 1'b1;
                end
                if (word && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ill = 1'b1;
            end
            OpcMiscMem: begin
                cls = ClsSys;
                ill = (f3[2:1] != 2'd0);
            end
            OpcSystem: begin
                if (f3 == 3'd0) begin
                    // Only ecall, ebreak, mret and wfi are recognised.
                    cls = ClsSys;
                    ill = !(inst[31:7] == 25'h0 || inst[31:7] == 25'h2000 ||
                            inst[31:7] == 25'h604000 || inst[31:7] == 25'h20A000);
                end else if (f3 == 3'd4) begin
                    ill = 1'b1;
                end else begin
                    cls = ClsCsr; rde = 1'b1; fn = f3;
                    csr = csr_op_e'(f3[1:0]);
                    if (f3[2]) gen = GenZimm;
                    else       r1e = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
    end

    logic [XLEN-1:0] imm_raw;

    always_comb begin
        imm_raw = '0;
        case (gen)
            GenI:     imm_raw = {{(XLEN-12){inst[31]}}, inst[31:20]};
            GenS:     imm_raw = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            GenB:     imm_raw = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                                 inst[11:8], 1'b0};
            GenU:     imm_raw = {{(XLEN-32){inst[31]}}, inst[31:12], 12'd0};
            GenJ:     imm_raw = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                                 inst[30:21], 1'b0};
            GenShamt: imm_raw = XLEN'(inst[25:20]);
            GenZimm:  imm_raw = XLEN'(inst[19:15]);
            default:  imm_raw = '0;
        endcase
    end

    always_comb begin
        illegal = ill;
        rs1_en  = r1e & ~ill;
        rs2_en  = r2e & ~ill;
        rd_en   = rde & ~ill & (inst[11:7] != 5'd0);
        rs1     = rs1_en ? inst[19:15] : 5'd0;
        rs2     = rs2_en ? inst[24:20] : 5'd0;
        rd      = rd_en  ? inst[11:7]  : 5'd0;
        imm     = ill ? '0 : imm_raw;
        uop     = ill ? UOP_W'(pack_uop(AluAdd, ClsTrap, 3'd0, 1'b0, 1'b0, 1'b0, CsrNone))
                      : UOP_W'(pack_uop(alu, cls, fn, word, use_imm, use_pc, csr));
    end

endmodule

// File: rtl/id_queue_stage.sv
// Decode stage: DEPTH-entry {pc,inst} FIFO feeding a registered decoded output slot, with
// an empty-FIFO bypass so a lone instruction reaches EX one cycle after acceptance.
module id_queue_stage
    import id_queue_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned PC_W  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned UOP_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [PC_W-1:0]            in_pc_i,
    input  logic [ILEN-1:0]            in_inst_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PC_W-1:0]            out_pc_o,
    output logic [ILEN-1:0]            out_inst_o,
    output logic [4:0]                 out_rs1_o,
    output logic [4:0]                 out_rs2_o,
    output logic [4:0]                 out_rd_o,
    output logic                       out_rs1_en_o,
    output logic                       out_rs2_en_o,
    output logic                       out_rd_en_o,
    output logic [XLEN-1:0]            out_imm_o,
    output logic [UOP_W-1:0]           out_uop_o,
    output logic                       out_illegal_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);

    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic [ILEN-1:0] inst_mem [DEPTH];

    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q, count_d;

    logic             out_valid_q, out_rs1_en_q, out_rs2_en_q, out_rd_en_q, out_illegal_q;
    logic [PC_W-1:0]  out_pc_q;
    logic [ILEN-1:0]  out_inst_q;
    logic [4:0]       out_rs1_q, out_rs2_q, out_rd_q;
    logic [XLEN-1:0]  out_imm_q;
    logic [UOP_W-1:0] out_uop_q;

    logic push, load, fifo_nonempty, pop, fifo_wr, src_valid;
    logic [PC_W-1:0] src_pc;
    logic [ILEN-1:0] src_inst;

    assign fifo_nonempty = (count_q != CntW'(0));
    assign in_ready_o    = (count_q != CntW'(DEPTH));
    assign push          = in_valid_i & in_ready_o;
    assign load          = ~out_valid_q | out_ready_i;
    assign pop           = load & fifo_nonempty;
    // A push bypasses the FIFO only when it goes straight into a free slot.
    assign fifo_wr       = push & ~(load & ~fifo_nonempty);
    assign src_valid     = fifo_nonempty | push;
    assign src_pc        = fifo_nonempty ? pc_mem[rd_ptr_q]   : in_pc_i;
    assign src_inst      = fifo_nonempty ? inst_mem[rd_ptr_q] : in_inst_i;

    always_comb begin
        count_d = count_q + CntW'(fifo_wr) - CntW'(pop);
    end

    logic [4:0]       dec_rs1, dec_rs2, dec_rd;
    logic             dec_rs1_en, dec_rs2_en, dec_rd_en, dec_illegal;
    logic [XLEN-1:0]  dec_imm;
    logic [UOP_W-1:0] dec_uop;

    id_queue_stage_decode_core #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .UOP_W (UOP_W)
    ) u_decode_core (
        .inst    (src_inst),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .rs1_en  (dec_rs1_en),
        .rs2_en  (dec_rs2_en),
        .rd_en   (dec_rd_en),
        .imm     (dec_imm),
        .uop     (dec_uop),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (fifo_wr && !flush_i && !rst) begin
            pc_mem[wr_ptr_q]   <= in_pc_i;
            inst_mem[wr_ptr_q] <= in_inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_inst_q    <= '0;
            out_rs1_q     <= '0;
            out_rs2_q     <= '0;
            out_rd_q      <= '0;
            out_rs1_en_q  <= 1'b0;
            out_rs2_en_q  <= 1'b0;
            out_rd_en_q   <= 1'b0;
            out_imm_q     <= '0;
            out_uop_q     <= '0;
            out_illegal_q <= 1'b0;
        end else if (flush_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_q + PtrW'(pop);
            wr_ptr_q <= wr_ptr_q + PtrW'(fifo_wr);
            if (load) begin
                out_valid_q <= src_valid;
                if (src_valid) begin
                    out_pc_q      <= src_pc;
                    out_inst_q    <= src_inst;
                    out_rs1_q     <= dec_rs1;
                    out_rs2_q     <= dec_rs2;
                    out_rd_q      <= dec_rd;
                    out_rs1_en_q  <= dec_rs1_en;
                    out_rs2_en_q  <= dec_rs2_en;
                    out_rd_en_q   <= dec_rd_en;
                    out_imm_q     <= dec_imm;
                    out_uop_q     <= dec_uop;
                    out_illegal_q <= dec_illegal;
                end
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_pc_o      = out_pc_q;
    assign out_inst_o    = out_inst_q;
    assign out_rs1_o     = out_rs1_q;
    assign out_rs2_o     = out_rs2_q;
    assign out_rd_o      = out_rd_q;
    assign out_rs1_en_o  = out_rs1_en_q;
    assign out_rs2_en_o  = out_rs2_en_q;
    assign out_rd_en_o   = out_rd_en_q;
    assign out_imm_o     = out_imm_q;
    assign out_uop_o     = out_uop_q;
    assign out_illegal_o = out_illegal_q;
    assign occupancy_o   = count_q;

endmodule

// File: tb/tb_id_queue_stage.sv
// Scoreboard bench for id_queue_stage: directed handshake/flush/reset cases, then random
// push/pop/flush traffic checked against a hand-decoded instruction table.
module tb_id_queue_stage;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_pc, out_pc, out_imm;
    logic [31:0] in_inst, out_inst, out_uop;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rs1_en, out_rs2_en, out_rd_en, out_illegal;
    logic [2:0]  occupancy;

    id_queue_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_pc_i       (in_pc),
        .in_inst_i     (in_inst),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_pc_o      (out_pc),
        .out_inst_o    (out_inst),
        .out_rs1_o     (out_rs1),
        .out_rs2_o     (out_rs2),
        .out_rd_o      (out_rd),
        .out_rs1_en_o  (out_rs1_en),
        .out_rs2_en_o  (out_rs2_en),
        .out_rd_en_o   (out_rd_en),
        .out_imm_o     (out_imm),
        .out_uop_o     (out_uop),
        .out_illegal_o (out_illegal),
        .occupancy_o   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rs1, rs2, rd;
        logic        rs1_en, rs2_en, rd_en;
        logic [63:0] imm;
        logic [2:0]  cls;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        int          idx;
    } sb_entry_t;

    vec_t      tbl [16];
    sb_entry_t sb  [$];
    int        n_vec = 0;
    int        n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_occ();
        return (sb.size() == 0) ? 0 : sb.size() - 1;
    endfunction

    // Called just after a falling edge: outputs reflect the last rising edge.
    task automatic check_state();
        sb_entry_t h;
        vec_t      v;
        check_eq("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        check_eq("occupancy", 64'(occupancy), 64'(exp_occ()));
        check_eq("in_ready", 64'(in_ready), 64'(exp_occ() != 4));
        if (sb.size() != 0) begin
            h = sb[0];
            v = tbl[h.idx];
            check_eq("pc", out_pc, h.pc);
            check_eq("inst", 64'(out_inst), 64'(v.inst));
            check_eq("rs1", 64'(out_rs1), 64'(v.rs1));
            check_eq("rs2", 64'(out_rs2), 64'(v.rs2));
            check_eq("rd", 64'(out_rd), 64'(v.rd));
            check_eq("en", 64'({out_rs1_en, out_rs2_en, out_rd_en}),
                     64'({v.rs1_en, v.rs2_en, v.rd_en}));
            check_eq("imm", out_imm, v.imm);
            check_eq("uop_cls", 64'(out_uop[6:4]), 64'(v.cls));
            check_eq("illegal", 64'(out_illegal), 64'(v.ill));
            if (v.ill) check_eq("uop_trap", 64'(out_uop), 64'h70);
        end
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, then check.
    task automatic step(input logic fl, input logic vld, input int idx, input logic [63:0] pc,
                        input logic rdy);
        logic acc;
        flush     = fl;
        in_valid  = vld;
        in_pc     = pc;
        in_inst   = tbl[idx].inst;
        out_ready = rdy;
        acc       = vld && (exp_occ() != 4);
        if (fl) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && rdy) void'(sb.pop_front());
            if (acc) sb.push_back('{pc: pc, idx: idx});
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check_state();
        check_eq("rst_pc", out_pc, 64'd0);
        check_eq("rst_inst", 64'(out_inst), 64'd0);
        check_eq("rst_imm", out_imm, 64'd0);
        check_eq("rst_uop", 64'(out_uop), 64'd0);
        check_eq("rst_regs", 64'({out_rs1, out_rs2, out_rd, out_illegal}), 64'd0);
    endtask

    initial begin
        //          inst           rs1    rs2    rd      e1    e2    ed    imm                     cls   ill
        tbl[0]  = '{32'h00500093, 5'd0, 5'd0,  5'd1,  1'b1, 1'b0, 1'b1, 64'd5,                  3'd0, 1'b0};
        tbl[1]  = '{32'hFFFFFFFF, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 64'd0,                  3'd7, 1'b1};
        tbl[2]  = '{32'h00000013, 5'd0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 64'd0,                  3'd0, 1'b0};
        tbl[3]  = '{32'h002081B3, 5'd1, 5'd2,  5'd3,  1'b1, 1'b1, 1'b1, 64'd0,                  3'd0, 1'b0};
        tbl[4]  = '{32'h407302B3, 5'd6, 5'd7,  5'd5,  1'b1, 1'b1, 1'b1, 64'd0,                  3'd0, 1'b0};
        tbl[5]  = '{32'hFFC12503, 5'd2, 5'd0,  5'd10, 1'b1, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
        tbl[6]  = '{32'h00B13423, 5'd2, 5'd11, 5'd0,  1'b1, 1'b1, 1'b0, 64'd8,                  3'd2, 1'b0};
        tbl[7]  = '{32'hFE208CE3, 5'd1, 5'd2,  5'd0,  1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};
        tbl[8]  = '{32'h800003B7, 5'd0, 5'd0,  5'd7,  1'b0, 1'b0, 1'b1, 64'hFFFFFFFF80000000, 3'd0, 1'b0};
        tbl[9]  = '{32'h001000EF, 5'd0, 5'd0,  5'd1,  1'b0, 1'b0, 1'b1, 64'h800,                3'd4, 1'b0};
        tbl[10] = '{32'h43F25213, 5'd4, 5'd0,  5'd4,  1'b1, 1'b0, 1'b1, 64'd63,                 3'd0, 1'b0};
        tbl[11] = '{32'h30002173, 5'd0, 5'd0,  5'd2,  1'b1, 1'b0, 1'b1, 64'd0,                  3'd5, 1'b0};
        tbl[12] = '{32'h00000073, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 64'd0,                  3'd6, 1'b0};
        tbl[13] = '{32'h00007003, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 64'd0,                  3'd7, 1'b1};
        tbl[14] = '{32'h02208133, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 64'd0,                  3'd7, 1'b1};
        tbl[15] = '{32'h00001297, 5'd0, 5'd0,  5'd5,  1'b0, 1'b0, 1'b1, 64'h1000,               3'd0, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        @(negedge clk);
        do_reset();

        // addi x1,x0,5 appears the cycle after acceptance
        step(1'b0, 1'b1, 0, 64'h1000, 1'b1);
        step(1'b0, 1'b0, 0, 64'h0, 1'b1);

        // Stall EX: slot + 4 FIFO entries, sixth offer refused; then full with a pop
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, k + 3, 64'h2000 + 64'(4 * k), 1'b0);
        step(1'b0, 1'b1, 9, 64'h2014, 1'b1);
        step(1'b0, 1'b1, 9, 64'h2014, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 0, 64'h0, 1'b1);

        // Flush with 3 queued and a same-cycle offer, then a lone instruction
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, k + 10, 64'h3000 + 64'(4 * k), 1'b0);
        step(1'b1, 1'b1, 15, 64'h3100, 1'b0);
        step(1'b0, 1'b1, 15, 64'h3200, 1'b1);
        step(1'b0, 1'b0, 0, 64'h0, 1'b1);

        // Every table entry back-to-back
        for (int k = 0; k < 16; k++) step(1'b0, 1'b1, k, 64'h4000 + 64'(4 * k), 1'b1);
        step(1'b0, 1'b0, 0, 64'h0, 1'b1);

        // Reset mid-stream drops everything
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, k, 64'h5000 + 64'(4 * k), 1'b0);
        do_reset();

        for (int c = 0; c < 10000; c++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 15)), {$urandom, $urandom}, $urandom_range(0, 2) != 0);
        end
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 0, 64'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
